// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID probe controller.
// State encoding, slave word addresses and the read-latency counter width.
package sysid_check_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_ID   = 3'd1,
      ST_RD_TS   = 3'd2,
      ST_COMPARE = 3'd3,
      ST_WAIT    = 3'd4
   } state_t;

   localparam logic ADDR_ID = 1'b0;
   localparam logic ADDR_TS = 1'b1;
   localparam int   LAT_W   = 4;

   function automatic logic is_busy(input state_t s);
      return (s == ST_RD_ID) || (s == ST_RD_TS) || (s == ST_COMPARE);
   endfunction

endpackage

// File: rtl/sysid_check_cnt.sv
// Loadable down-counter that sticks at zero instead of wrapping.
// Load has priority over decrement; zero reflects the registered count.
module sysid_check_cnt #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/sysid_check_ctrl.sv
// Probes the sysid slave (ID word, then timestamp), compares against build-time
// values and reports registered pass/mismatch/sticky-error status.
module sysid_check_ctrl
   import sysid_check_pkg::*;
#(
   parameter logic [31:0] EXP_ID         = 32'h0000_0000,
   parameter logic [31:0] EXP_TS         = 32'h4FC3_2AE3,
   parameter int          READ_LAT       = 1,
   parameter int          RECHECK_CYCLES = 0,
   parameter int          CNT_W          = 32,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        clr_err,
   output logic        sys_address,
   output logic        sys_read,
   input  logic [31:0] sys_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        id_mismatch,
   output logic        ts_mismatch,
   output logic        err_sticky,
   output logic [31:0] captured_id,
   output logic [31:0] captured_ts
);

   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LAT);
   localparam logic [CNT_W-1:0] RC_LOAD  = (RECHECK_CYCLES > 0) ? CNT_W'(RECHECK_CYCLES - 1) : '0;

   state_t      state_q, state_d;
   logic        auto_q, auto_d;
   logic        wait_ld_q, wait_ld_d;
   logic [31:0] rd_id_q, rd_id_d;
   logic [31:0] rd_ts_q, rd_ts_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        id_mis_q, id_mis_d;
   logic        ts_mis_q, ts_mis_d;
   logic        err_q, err_d;
   logic [31:0] cap_id_q, cap_id_d;
   logic [31:0] cap_ts_q, cap_ts_d;

   logic        lat_load, lat_dec, lat_zero;
   logic        rc_load, rc_dec, rc_zero;
   logic        id_diff, ts_diff;

   assign id_diff = (rd_id_q != EXP_ID);
   assign ts_diff = (rd_ts_q != EXP_TS);

   always_comb begin
      state_d   = state_q;
      auto_d    = 1'b0;
      wait_ld_d = wait_ld_q;
      rd_id_d   = rd_id_q;
      rd_ts_d   = rd_ts_q;
      done_d    = 1'b0;
      pass_d    = pass_q;
      id_mis_d  = id_mis_q;
      ts_mis_d  = ts_mis_q;
      cap_id_d  = cap_id_q;
      cap_ts_d  = cap_ts_q;
      lat_load  = 1'b0;
      lat_dec   = 1'b0;
      rc_load   = 1'b0;
      rc_dec    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start || auto_q) begin
               state_d  = ST_RD_ID;
               lat_load = 1'b1;
            end
         end
         ST_RD_ID: begin
            if (lat_zero) begin
               rd_id_d  = sys_readdata;
               state_d  = ST_RD_TS;
               lat_load = 1'b1;
            end else begin
               lat_dec = 1'b1;
            end
         end
         ST_RD_TS: begin
            if (lat_zero) begin
               rd_ts_d = sys_readdata;
               state_d = ST_COMPARE;
            end else begin
               lat_dec = 1'b1;
            end
         end
         ST_COMPARE: begin
            done_d   = 1'b1;
            pass_d   = !(id_diff || ts_diff);
            id_mis_d = id_diff;
            ts_mis_d = ts_diff;
            cap_id_d = rd_id_q;
            cap_ts_d = rd_ts_q;
            if (RECHECK_CYCLES == 0) begin
               state_d = ST_IDLE;
            end else begin
               state_d   = ST_WAIT;
               wait_ld_d = 1'b1;
            end
         end
         ST_WAIT: begin
            // The interval counter is loaded in the first WAIT cycle, then counted down.
            if (start) begin
               state_d   = ST_RD_ID;
               lat_load  = 1'b1;
               wait_ld_d = 1'b0;
            end else if (wait_ld_q) begin
               rc_load   = 1'b1;
               wait_ld_d = 1'b0;
            end else if (rc_zero) begin
               state_d  = ST_RD_ID;
               lat_load = 1'b1;
            end else begin
               rc_dec = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A failing result beats clr_err both on the compare edge and during the done cycle.
      err_d = err_q;
      if (clr_err && !(done_q && !pass_q)) begin
         err_d = 1'b0;
      end
      if ((state_q == ST_COMPARE) && (id_diff || ts_diff)) begin
         err_d = 1'b1;
      end

      busy_d = is_busy(state_d);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         auto_q    <= AUTO_START;
         wait_ld_q <= 1'b0;
         rd_id_q   <= '0;
         rd_ts_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         id_mis_q  <= 1'b0;
         ts_mis_q  <= 1'b0;
         err_q     <= 1'b0;
         cap_id_q  <= '0;
         cap_ts_q  <= '0;
      end else begin
         state_q   <= state_d;
         auto_q    <= auto_d;
         wait_ld_q <= wait_ld_d;
         rd_id_q   <= rd_id_d;
         rd_ts_q   <= rd_ts_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         id_mis_q  <= id_mis_d;
         ts_mis_q  <= ts_mis_d;
         err_q     <= err_d;
         cap_id_q  <= cap_id_d;
         cap_ts_q  <= cap_ts_d;
      end
   end

   sysid_check_cnt #(.W(LAT_W)) u_lat_cnt (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (lat_load),
      .load_val (LAT_LOAD),
      .dec      (lat_dec),
      .zero     (lat_zero)
   );

   sysid_check_cnt #(.W(CNT_W)) u_rc_cnt (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (rc_load),
      .load_val (RC_LOAD),
      .dec      (rc_dec),
      .zero     (rc_zero)
   );

   assign sys_address = (state_q == ST_RD_TS) ? ADDR_TS : ADDR_ID;
   assign sys_read    = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign id_mismatch = id_mis_q;
   assign ts_mismatch = ts_mis_q;
   assign err_sticky  = err_q;
   assign captured_id = cap_id_q;
   assign captured_ts = cap_ts_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench: one-shot controller (A) and a periodic re-probe controller (B),
// each fed by a one-cycle-latency sysid slave model.
module tb_sysid_check_ctrl;

   localparam logic [31:0] EXP_TS = 32'h4FC3_2AE3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a_n, start_a, clr_a;
   logic        addr_a, read_a, busy_a, done_a, pass_a, id_mis_a, ts_mis_a, err_a;
   logic [31:0] rdata_a = '0;
   logic [31:0] cap_id_a, cap_ts_a;
   logic [31:0] id_word_a, ts_word_a;

   logic        rst_b_n, start_b, clr_b;
   logic        addr_b, read_b, busy_b, done_b, pass_b, id_mis_b, ts_mis_b, err_b;
   logic [31:0] rdata_b = '0;
   logic [31:0] cap_id_b, cap_ts_b;

   int checks = 0;
   int errors = 0;

   always @(posedge clk) rdata_a <= addr_a ? ts_word_a : id_word_a;
   always @(posedge clk) rdata_b <= addr_b ? EXP_TS : 32'h0;

   sysid_check_ctrl dut_a (
      .clock(clk), .reset_n(rst_a_n), .start(start_a), .clr_err(clr_a),
      .sys_address(addr_a), .sys_read(read_a), .sys_readdata(rdata_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .id_mismatch(id_mis_a),
      .ts_mismatch(ts_mis_a), .err_sticky(err_a),
      .captured_id(cap_id_a), .captured_ts(cap_ts_a)
   );

   sysid_check_ctrl #(.RECHECK_CYCLES(10)) dut_b (
      .clock(clk), .reset_n(rst_b_n), .start(start_b), .clr_err(clr_b),
      .sys_address(addr_b), .sys_read(read_b), .sys_readdata(rdata_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .id_mismatch(id_mis_b),
      .ts_mismatch(ts_mis_b), .err_sticky(err_b),
      .captured_id(cap_id_b), .captured_ts(cap_ts_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done_a(output int n);
      n = 0;
      while (!done_a && n < 60) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_done_b(output int n);
      n = 0;
      while (!done_b && n < 60) begin
         tick();
         n++;
      end
   endtask

   task automatic pulse_start_a();
      @(negedge clk);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int dn;
      rst_a_n = 1'b0; start_a = 1'b0; clr_a = 1'b0;
      rst_b_n = 1'b0; start_b = 1'b0; clr_b = 1'b0;
      id_word_a = 32'h0; ts_word_a = EXP_TS;
      repeat (3) tick();

      check("rst_done", done_a, 1'b0);
      check("rst_read", read_a, 1'b0);
      check("rst_busy", busy_a, 1'b0);
      check("rst_pass", pass_a, 1'b0);
      check("rst_err", err_a, 1'b0);
      check("rst_cap_ts", cap_ts_a, 32'h0);

      // Auto-start probe after reset release, good image
      @(negedge clk);
      rst_a_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         check($sformatf("t1_done_e%0d", k), done_a, (k == 6));
         if (k == 1) begin
            check("t1_read_id", read_a, 1'b1);
            check("t1_addr_id", addr_a, 1'b0);
            check("t1_busy", busy_a, 1'b1);
         end
         if (k == 3) check("t1_addr_ts", addr_a, 1'b1);
      end
      $display("probe A auto: pass=%0d id=%h ts=%h", pass_a, cap_id_a, cap_ts_a);
      check("t1_pass", pass_a, 1'b1);
      check("t1_err", err_a, 1'b0);
      check("t1_cap_id", cap_id_a, 32'h0);
      check("t1_cap_ts", cap_ts_a, EXP_TS);
      check("t1_id_mis", id_mis_a, 1'b0);
      check("t1_ts_mis", ts_mis_a, 1'b0);
      tick();
      check("t1_done_pulse", done_a, 1'b0);
      check("t1_idle_busy", busy_a, 1'b0);
      check("t1_idle_read", read_a, 1'b0);

      // ID word wrong
      id_word_a = 32'h0000_0001;
      pulse_start_a();
      wait_done_a(n);
      $display("probe A bad id: lat=%0d pass=%0d id=%h", n, pass_a, cap_id_a);
      check("t2_latency", n, 5);
      check("t2_id_mis", id_mis_a, 1'b1);
      check("t2_ts_mis", ts_mis_a, 1'b0);
      check("t2_pass", pass_a, 1'b0);
      check("t2_err", err_a, 1'b1);
      check("t2_cap_id", cap_id_a, 32'h1);
      check("t2_cap_ts", cap_ts_a, EXP_TS);
      repeat (3) tick();
      check("t2_hold_pass", pass_a, 1'b0);
      check("t2_hold_cap_id", cap_id_a, 32'h1);
      check("t2_hold_done", done_a, 1'b0);

      // start held high through a whole probe: one done, nothing queued
      id_word_a = 32'h0;
      @(negedge clk);
      start_a = 1'b1;
      tick();
      wait_done_a(n);
      start_a = 1'b0;
      $display("probe A start held: lat=%0d pass=%0d", n, pass_a);
      check("t4_latency", n, 5);
      check("t4_pass", pass_a, 1'b1);
      check("t4_err_sticky", err_a, 1'b1);
      dn = 0;
      repeat (15) begin
         tick();
         if (done_a) dn++;
      end
      check("t4_extra_done", dn, 0);
      check("t4_busy", busy_a, 1'b0);

      // clr_err coinciding with a failing result
      id_word_a = 32'h0000_0001;
      @(negedge clk);
      clr_a = 1'b1;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_done_a(n);
      $display("probe A clr+fail: lat=%0d err=%0d", n, err_a);
      check("t5_latency", n, 5);
      check("t5_err_at_done", err_a, 1'b1);
      tick();
      clr_a = 1'b0;
      check("t5_err_after_done", err_a, 1'b1);
      tick();
      check("t5_err_hold", err_a, 1'b1);
      @(negedge clk);
      clr_a = 1'b1;
      tick();
      clr_a = 1'b0;
      check("t5_err_cleared", err_a, 1'b0);

      // Reset asserted during RD_TS
      id_word_a = 32'h0;
      pulse_start_a();
      tick();
      tick();
      check("t6_in_rd_ts_addr", addr_a, 1'b1);
      check("t6_in_rd_ts_read", read_a, 1'b1);
      #2;
      rst_a_n = 1'b0;
      #1;
      check("t6_rst_read", read_a, 1'b0);
      check("t6_rst_addr", addr_a, 1'b0);
      check("t6_rst_busy", busy_a, 1'b0);
      check("t6_rst_cap_id", cap_id_a, 32'h0);
      check("t6_rst_cap_ts", cap_ts_a, 32'h0);
      check("t6_rst_id_mis", id_mis_a, 1'b0);
      dn = 0;
      repeat (3) begin
         tick();
         if (done_a) dn++;
      end
      check("t6_no_done", dn, 0);
      @(negedge clk);
      rst_a_n = 1'b1;
      tick();
      wait_done_a(n);
      $display("probe A after reset: lat=%0d pass=%0d", n + 1, pass_a);
      check("t6_auto_latency", n + 1, 6);
      check("t6_pass", pass_a, 1'b1);

      // Periodic re-probe on B
      @(negedge clk);
      rst_b_n = 1'b1;
      tick();
      wait_done_b(n);
      $display("probe B first: lat=%0d pass=%0d", n + 1, pass_b);
      check("t3_first_latency", n + 1, 6);
      tick();
      wait_done_b(n);
      $display("probe B recheck: spacing=%0d pass=%0d", n + 1, pass_b);
      check("t3_spacing", n + 1, 16);
      check("t3_pass", pass_b, 1'b1);
      check("t3_id_mis", id_mis_b, 1'b0);
      check("t3_ts_mis", ts_mis_b, 1'b0);
      check("t3_cap_id", cap_id_b, 32'h0);
      check("t3_cap_ts", cap_ts_b, EXP_TS);
      check("t3_err", err_b, 1'b0);
      repeat (3) tick();
      check("t3_wait_busy", busy_b, 1'b0);
      check("t3_wait_read", read_b, 1'b0);
      @(negedge clk);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      check("t3_abort_read", read_b, 1'b1);
      check("t3_abort_addr", addr_b, 1'b0);
      check("t3_abort_busy", busy_b, 1'b1);
      wait_done_b(n);
      $display("probe B abort-wait: lat=%0d pass=%0d", n, pass_b);
      check("t3_abort_latency", n, 5);
      check("t3_abort_pass", pass_b, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
